// File: rtl/cmul_share_arb.sv
// Packet-locked round-robin arbiter sharing one complex multiplier among NPORTS
// AXI-stream requesters; an in-order tag FIFO routes each product back to its issuer.
module cmul_share_arb #(
    parameter int NPORTS     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int PWIDTH     = 16,
    parameter int TAG_AW     = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NPORTS*2*DATA_WIDTH-1:0] req_adata,
    input  logic [NPORTS*2*DATA_WIDTH-1:0] req_bdata,
    input  logic [NPORTS-1:0]              req_tvalid,
    input  logic [NPORTS-1:0]              req_tlast,
    output logic [NPORTS-1:0]              req_tready,
    output logic [2*DATA_WIDTH-1:0]        mul_adata,
    output logic [2*DATA_WIDTH-1:0]        mul_bdata,
    output logic                           mul_tvalid,
    output logic                           mul_tlast,
    input  logic                           mul_tready,
    input  logic [2*PWIDTH-1:0]            mul_pdata,
    input  logic                           mul_out_tvalid,
    input  logic                           mul_out_tlast,
    output logic                           mul_out_tready,
    output logic [2*PWIDTH-1:0]            out_pdata,
    output logic [NPORTS-1:0]              out_tvalid,
    output logic                           out_tlast,
    input  logic [NPORTS-1:0]              out_tready,
    output logic                           busy,
    output logic                           tag_err
);
    localparam int GW    = $clog2(NPORTS);
    localparam int OW    = 2 * DATA_WIDTH;
    localparam int DEPTH = 1 << TAG_AW;

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [GW-1:0]            g_q, g_d;
    logic [GW-1:0]            ptr_q, ptr_d;
    logic [DEPTH-1:0][GW-1:0] tag_q, tag_d;
    logic [TAG_AW-1:0]        wr_q, wr_d;
    logic [TAG_AW-1:0]        rd_q, rd_d;
    logic [TAG_AW:0]          cnt_q, cnt_d;
    logic                     tag_err_q, tag_err_d;

    logic          tag_full, tag_empty;
    logic          push, pop, pkt_end;
    logic          sel_valid, sel_last, head_rdy;
    logic [GW-1:0] pick, head;

    assign tag_full  = cnt_q[TAG_AW];
    assign tag_empty = (cnt_q == '0);
    assign head      = tag_q[rd_q];
    assign push      = mul_tvalid & mul_tready;
    assign pkt_end   = push & mul_tlast;
    assign out_pdata = mul_pdata;
    assign out_tlast = mul_out_tlast;
    assign busy      = (state_q == LOCK) | ~tag_empty;
    assign tag_err   = tag_err_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            g_q       <= '0;
            ptr_q     <= '0;
            tag_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            tag_q     <= tag_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            tag_err_q <= tag_err_d;
        end
    end

    // Ports below ptr are considered first so the group at/after ptr overrides them;
    // the downward scan leaves the lowest index of each group as the winner.
    always_comb begin
        pick = ptr_q;
        for (int p = NPORTS - 1; p >= 0; p--)
            if (req_tvalid[p] && (GW'(p) < ptr_q)) pick = GW'(p);
        for (int p = NPORTS - 1; p >= 0; p--)
            if (req_tvalid[p] && (GW'(p) >= ptr_q)) pick = GW'(p);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: if (|req_tvalid) begin
                state_d = LOCK;
                g_d     = pick;
            end
            LOCK: if (pkt_end) begin
                state_d = IDLE;
                ptr_d   = (g_q == GW'(NPORTS - 1)) ? '0 : g_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag FIFO bookkeeping and sticky error
    always_comb begin
        tag_d = tag_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            tag_d[wr_q] = g_q;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        tag_err_d = tag_err_q | (tag_empty & mul_out_tvalid);
    end

    // Issue-path outputs
    always_comb begin
        mul_adata  = '0;
        mul_bdata  = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        mul_tvalid = 1'b0;
        mul_tlast  = 1'b0;
        req_tready = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (g_q == GW'(p)) begin
                mul_adata = req_adata[p*OW +: OW];
                mul_bdata = req_bdata[p*OW +: OW];
                sel_valid = req_tvalid[p];
                sel_last  = req_tlast[p];
            end
        end
        if (state_q == LOCK) begin
            mul_tvalid = sel_valid & ~tag_full;
            mul_tlast  = sel_last;
            for (int p = 0; p < NPORTS; p++)
                if (g_q == GW'(p)) req_tready[p] = mul_tready & ~tag_full;
        end
    end

    // Return path: with no tag outstanding, products are drained and dropped
    always_comb begin
        head_rdy       = 1'b0;
        out_tvalid     = '0;
        mul_out_tready = 1'b1;
        pop            = 1'b0;
        for (int p = 0; p < NPORTS; p++)
            if (head == GW'(p)) head_rdy = out_tready[p];
        if (!tag_empty) begin
            mul_out_tready = head_rdy;
            pop            = mul_out_tvalid & head_rdy;
            for (int p = 0; p < NPORTS; p++)
                if (head == GW'(p)) out_tvalid[p] = mul_out_tvalid;
        end
    end

endmodule

// File: tb/tb_cmul_share_arb.sv
// Directed bench for cmul_share_arb; a latency-1 complex multiplier model stands in
// for the shared datapath when enabled, otherwise products are driven by hand.
module tb_cmul_share_arb;
    localparam int NP = 4;
    localparam int DW = 16;
    localparam int PW = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [NP*2*DW-1:0] req_adata, req_bdata;
    logic [NP-1:0]      req_tvalid, req_tlast, req_tready;
    logic [2*DW-1:0]    mul_adata, mul_bdata;
    logic               mul_tvalid, mul_tlast, mul_tready;
    logic [2*PW-1:0]    mul_pdata;
    logic               mul_out_tvalid, mul_out_tlast, mul_out_tready;
    logic [2*PW-1:0]    out_pdata;
    logic [NP-1:0]      out_tvalid, out_tready;
    logic               out_tlast, busy, tag_err;

    logic               model_en, man_out_tvalid, man_out_tlast;
    logic [2*PW-1:0]    man_pdata;
    logic               m_pv, m_pl;
    logic [2*PW-1:0]    m_pd;

    int checks   = 0;
    int failures = 0;
    int rem [NP];
    int npk [NP];
    int plen;

    always #5 clk = ~clk;

    cmul_share_arb #(.NPORTS(NP), .DATA_WIDTH(DW), .PWIDTH(PW), .TAG_AW(3)) dut (
        .clk(clk), .reset(reset),
        .req_adata(req_adata), .req_bdata(req_bdata),
        .req_tvalid(req_tvalid), .req_tlast(req_tlast), .req_tready(req_tready),
        .mul_adata(mul_adata), .mul_bdata(mul_bdata),
        .mul_tvalid(mul_tvalid), .mul_tlast(mul_tlast), .mul_tready(mul_tready),
        .mul_pdata(mul_pdata), .mul_out_tvalid(mul_out_tvalid),
        .mul_out_tlast(mul_out_tlast), .mul_out_tready(mul_out_tready),
        .out_pdata(out_pdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
        .out_tready(out_tready), .busy(busy), .tag_err(tag_err)
    );

    function automatic logic [31:0] cmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [15:0] ai, aq, bi, bq;
        logic signed [31:0] re, im;
        ai = a[31:16]; aq = a[15:0]; bi = b[31:16]; bq = b[15:0];
        re = ai * bi - aq * bq;
        im = ai * bq + aq * bi;
        return {re[15:0], im[15:0]};
    endfunction

    // Multiplier stand-in, reset from the same signal as the DUT
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pv <= 1'b0; m_pd <= '0; m_pl <= 1'b0;
        end else if (mul_tready) begin
            m_pv <= mul_tvalid;
            m_pd <= cmul(mul_adata, mul_bdata);
            m_pl <= mul_tlast;
        end
    end

    assign mul_out_tvalid = model_en ? m_pv : man_out_tvalid;
    assign mul_out_tlast  = model_en ? m_pl : man_out_tlast;
    assign mul_pdata      = model_en ? m_pd : man_pdata;

    task automatic set_port(input int p, input logic [15:0] ai, input logic [15:0] aq,
                            input logic [15:0] bi, input logic [15:0] bq);
        req_adata[p*32 +: 32] = {ai, aq};
        req_bdata[p*32 +: 32] = {bi, bq};
    endtask

    task automatic drive_ports;
        for (int p = 0; p < NP; p++) begin
            req_tvalid[p] = (rem[p] != 0);
            req_tlast[p]  = (rem[p] == 1);
        end
    endtask

    task automatic update_ports;
        logic [NP-1:0] hs;
        hs = req_tvalid & req_tready;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                rem[p]--;
                if (rem[p] == 0 && npk[p] > 0) begin
                    npk[p]--;
                    rem[p] = plen;
                end
            end
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        model_en = 1'b0; man_out_tvalid = 1'b0; man_out_tlast = 1'b0; man_pdata = '0;
        req_tvalid = '0; req_tlast = '0; mul_tready = 1'b0; out_tready = '0;
        for (int p = 0; p < NP; p++) begin rem[p] = 0; npk[p] = 0; end
        plen = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        req_adata = '0; req_bdata = '0;
        do_reset;
        reset = 1'b0;
        req_tvalid = 4'hF; mul_tready = 1'b1; out_tready = 4'hF;
        #1;
        checks++; if (req_tready !== 4'h0) begin failures++; $display("FAIL reset_req_tready got=%h exp=0", req_tready); end
        checks++; if (mul_tvalid !== 1'b0) begin failures++; $display("FAIL reset_mul_tvalid got=%b exp=0", mul_tvalid); end
        checks++; if (out_tvalid !== 4'h0) begin failures++; $display("FAIL reset_out_tvalid got=%h exp=0", out_tvalid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL reset_tag_err got=%b exp=0", tag_err); end
    endtask

    task automatic test_single_port;
        logic [3:0] exp_rdy [7];
        logic [3:0] exp_out [7];
        exp_rdy = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
        exp_out = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        do_reset;
        set_port(0, 16'd1, 16'd0, 16'd3, 16'd4);
        model_en = 1'b1; mul_tready = 1'b1; out_tready = 4'hF;
        rem[0] = 4;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_ports;
            #1;
            checks++; if (req_tready !== exp_rdy[i]) begin failures++; $display("FAIL single_rdy[%0d] got=%h exp=%h", i, req_tready, exp_rdy[i]); end
            checks++; if (out_tvalid !== exp_out[i]) begin failures++; $display("FAIL single_out_tvalid[%0d] got=%h exp=%h", i, out_tvalid, exp_out[i]); end
            if (i >= 1 && i <= 4) begin
                checks++; if (mul_adata !== 32'h0001_0000) begin failures++; $display("FAIL single_mul_adata[%0d] got=%h exp=00010000", i, mul_adata); end
                checks++; if (mul_tlast !== (i == 4)) begin failures++; $display("FAIL single_mul_tlast[%0d] got=%b exp=%b", i, mul_tlast, (i == 4)); end
            end
            if (i >= 2 && i <= 5) begin
                checks++; if (out_pdata !== 32'h0003_0004) begin failures++; $display("FAIL single_pdata[%0d] got=%h exp=00030004", i, out_pdata); end
                checks++; if (out_tlast !== (i == 5)) begin failures++; $display("FAIL single_out_tlast[%0d] got=%b exp=%b", i, out_tlast, (i == 5)); end
            end
            if (i == 3) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_mid got=%b exp=1", busy); end
            end
            if (i == 6) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
            end
            update_ports;
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rdy [16];
        logic [3:0] exp_out [16];
        exp_rdy = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                    4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0};
        exp_out = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
                    4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
        do_reset;
        set_port(1, 16'd0, 16'd0, 16'd0, 16'd0);
        set_port(2, 16'd2, 16'd1, 16'd3, 16'd5);
        set_port(3, 16'd0, 16'd0, 16'd0, 16'd0);
        model_en = 1'b1; mul_tready = 1'b1; out_tready = 4'hF;
        plen = 2;
        for (int p = 0; p < NP; p++) rem[p] = 2;
        npk[0] = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive_ports;
            #1;
            checks++; if (req_tready !== exp_rdy[i]) begin failures++; $display("FAIL rr_rdy[%0d] got=%h exp=%h", i, req_tready, exp_rdy[i]); end
            checks++; if (out_tvalid !== exp_out[i]) begin failures++; $display("FAIL rr_out_tvalid[%0d] got=%h exp=%h", i, out_tvalid, exp_out[i]); end
            if (i == 8 || i == 9) begin
                checks++; if (out_pdata !== 32'h0001_000D) begin failures++; $display("FAIL rr_pdata_p2[%0d] got=%h exp=0001000d", i, out_pdata); end
                checks++; if (out_tlast !== (i == 9)) begin failures++; $display("FAIL rr_tlast_p2[%0d] got=%b exp=%b", i, out_tlast, (i == 9)); end
            end
            update_ports;
        end
    endtask

    task automatic test_backpressure;
        int issued, popped;
        issued = 0; popped = 0;
        do_reset;
        mul_tready = 1'b1;
        rem[2] = 10;
        for (int i = 0; i < 40 && popped < 10; i++) begin
            @(negedge clk);
            drive_ports;
            man_out_tvalid = (issued > popped);
            man_out_tlast  = (popped == 9);
            man_pdata      = {16'h00A0, 16'(popped)};
            out_tready     = (i >= 12) ? 4'b0100 : 4'b0000;
            #1;
            if (i >= 9 && i <= 12) begin
                checks++; if (req_tready !== 4'h0) begin failures++; $display("FAIL bp_full_rdy[%0d] got=%h exp=0", i, req_tready); end
                checks++; if (mul_tvalid !== 1'b0) begin failures++; $display("FAIL bp_full_mul_tvalid[%0d] got=%b exp=0", i, mul_tvalid); end
            end
            if (i == 13) begin
                checks++; if (req_tready !== 4'b0100) begin failures++; $display("FAIL bp_resume_rdy got=%h exp=4", req_tready); end
            end
            if (man_out_tvalid) begin
                checks++; if (out_tvalid !== 4'b0100) begin failures++; $display("FAIL bp_out_tvalid[%0d] got=%h exp=4", i, out_tvalid); end
                checks++; if (mul_out_tready !== out_tready[2]) begin failures++; $display("FAIL bp_mul_out_tready[%0d] got=%b exp=%b", i, mul_out_tready, out_tready[2]); end
                checks++; if (out_pdata !== man_pdata) begin failures++; $display("FAIL bp_pdata[%0d] got=%h exp=%h", i, out_pdata, man_pdata); end
                if (man_out_tlast) begin
                    checks++; if (out_tlast !== 1'b1) begin failures++; $display("FAIL bp_out_tlast got=%b exp=1", out_tlast); end
                end
            end
            if (req_tvalid[2] && req_tready[2]) issued++;
            if (man_out_tvalid && out_tready[2]) popped++;
            update_ports;
        end
        checks++; if (issued != 10) begin failures++; $display("FAIL bp_issued got=%0d exp=10", issued); end
        checks++; if (popped != 10) begin failures++; $display("FAIL bp_popped_timeout got=%0d exp=10", popped); end
        @(negedge clk);
        man_out_tvalid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_end got=%b exp=0", busy); end
        checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL bp_tag_err got=%b exp=0", tag_err); end
    endtask

    task automatic test_wrap;
        logic [3:0] exp_rdy [7];
        logic [3:0] exp_out [7];
        exp_rdy = '{4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h2, 4'h0};
        exp_out = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h2};
        do_reset;
        model_en = 1'b1; mul_tready = 1'b1; out_tready = 4'hF;
        rem[2] = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 2) begin rem[1] = 1; rem[3] = 1; end
            drive_ports;
            #1;
            checks++; if (req_tready !== exp_rdy[i]) begin failures++; $display("FAIL wrap_rdy[%0d] got=%h exp=%h", i, req_tready, exp_rdy[i]); end
            checks++; if (out_tvalid !== exp_out[i]) begin failures++; $display("FAIL wrap_out_tvalid[%0d] got=%h exp=%h", i, out_tvalid, exp_out[i]); end
            update_ports;
        end
    endtask

    task automatic test_spurious;
        do_reset;
        @(negedge clk);
        man_out_tvalid = 1'b1; man_pdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (mul_out_tready !== 1'b1) begin failures++; $display("FAIL spur_drain_ready got=%b exp=1", mul_out_tready); end
        checks++; if (out_tvalid !== 4'h0) begin failures++; $display("FAIL spur_out_tvalid got=%h exp=0", out_tvalid); end
        checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL spur_tag_err_pre got=%b exp=0", tag_err); end
        @(negedge clk);
        man_out_tvalid = 1'b0;
        #1;
        checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL spur_tag_err_set got=%b exp=1", tag_err); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL spur_tag_err_sticky got=%b exp=1", tag_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_busy got=%b exp=0", busy); end
        reset = 1'b0;
        #1;
        checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL spur_tag_err_clear got=%b exp=0", tag_err); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_packet;
        logic [3:0] exp_rdy [5];
        logic [3:0] exp_out [5];
        exp_rdy = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
        exp_out = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2};
        do_reset;
        set_port(1, 16'd2, 16'd3, 16'd4, 16'd1);
        mul_tready = 1'b1;
        rem[0] = 5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_ports;
            #1;
            update_ports;
        end
        @(negedge clk);
        drive_ports;
        #1;
        checks++; if (mul_tvalid !== 1'b1) begin failures++; $display("FAIL rmid_beat3_valid got=%b exp=1", mul_tvalid); end
        reset = 1'b0;
        #1;
        checks++; if (req_tready !== 4'h0) begin failures++; $display("FAIL rmid_rdy got=%h exp=0", req_tready); end
        checks++; if (mul_tvalid !== 1'b0) begin failures++; $display("FAIL rmid_mul_tvalid got=%b exp=0", mul_tvalid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (out_tvalid !== 4'h0) begin failures++; $display("FAIL rmid_out_tvalid got=%h exp=0", out_tvalid); end
        rem[0] = 0;
        drive_ports;
        @(negedge clk);
        reset = 1'b1;
        // A product still in flight from before reset has no tag
        @(negedge clk);
        man_out_tvalid = 1'b1;
        #1;
        checks++; if (out_tvalid !== 4'h0) begin failures++; $display("FAIL rmid_stale_out got=%h exp=0", out_tvalid); end
        @(negedge clk);
        man_out_tvalid = 1'b0;
        #1;
        checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL rmid_stale_tag_err got=%b exp=1", tag_err); end
        model_en = 1'b1; out_tready = 4'hF;
        rem[1] = 3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_ports;
            #1;
            checks++; if (req_tready !== exp_rdy[i]) begin failures++; $display("FAIL rmid_new_rdy[%0d] got=%h exp=%h", i, req_tready, exp_rdy[i]); end
            checks++; if (out_tvalid !== exp_out[i]) begin failures++; $display("FAIL rmid_new_out[%0d] got=%h exp=%h", i, out_tvalid, exp_out[i]); end
            if (i == 4) begin
                checks++; if (out_pdata !== 32'h0005_000E) begin failures++; $display("FAIL rmid_new_pdata got=%h exp=0005000e", out_pdata); end
                checks++; if (out_tlast !== 1'b1) begin failures++; $display("FAIL rmid_new_tlast got=%b exp=1", out_tlast); end
            end
            update_ports;
        end
    endtask

    initial begin
        test_reset;
        test_single_port;
        test_round_robin;
        test_backpressure;
        test_wrap;
        test_spurious;
        test_reset_mid_packet;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmul_share_arb.md
# cmul_share_arb

Packet-level round-robin arbiter that shares one pipelined complex multiplier (the `cmuldk` datapath) among `NPORTS` AXI-stream requesters. Each requester presents an operand pair (`adata`, `bdata`). The block locks a grant for a whole packet, which is delimited by `tlast`, and forwards that requester's beats to the multiplier. It records the issuing port of every beat in an in-order tag FIFO, and uses the tag to route each product back to the requester that issued it. The block sits between per-channel sample sources (mixers, correlators) and the single shared `cmuldk` instance.

## Interface
- `NPORTS`, 4: number of requesters; range 2–8.
- `DATA_WIDTH`, 16: width of the I and Q operand components.
- `PWIDTH`, 16: width of the I and Q product components.
- `TAG_AW`, 3: log2 of the tag FIFO depth. Depth is 8 and must be ≥ multiplier latency plus 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_adata`  in  `NPORTS*2*DATA_WIDTH`  per-port operand A; port p occupies slice p; I is the upper half, Q the lower half.
- `req_bdata`  in  `NPORTS*2*DATA_WIDTH`  per-port operand B; same packing as `req_adata`.
- `req_tvalid`  in  `NPORTS`  per-port beat valid.
- `req_tlast`  in  `NPORTS`  per-port end of packet.
- `req_tready`  out  `NPORTS`  per-port ready.
- `mul_adata`, `mul_bdata`  out  `2*DATA_WIDTH`  operands driven to the multiplier.
- `mul_tvalid`, `mul_tlast`  out  1  multiplier input valid and last.
- `mul_tready`  in  1  multiplier input ready.
- `mul_pdata`  in  `2*PWIDTH`  product from the multiplier.
- `mul_out_tvalid`, `mul_out_tlast`  in  1  product valid and last.
- `mul_out_tready`  out  1  product ready.
- `out_pdata`  out  `2*PWIDTH`  product, shared by all output ports.
- `out_tvalid`, `out_tlast`  out  `NPORTS` / 1  per-port product valid (one-hot) and last.
- `out_tready`  in  `NPORTS`  per-port product ready.
- `busy`  out  1  high when a grant is held or the tag FIFO is non-empty.
- `tag_err`  out  1  sticky; set when a product arrives while the tag FIFO is empty.

## Operation
- State machine states:
  - `IDLE`: no grant held.
  - `LOCK`: grant held for port `g`.
- Round-robin pointer `ptr` holds the highest-priority port.
- `IDLE` → `LOCK`:
  - Taken when any `req_tvalid` is high.
  - `g` = first port with `req_tvalid` set, searching from `ptr` upward with wrap-around.
  - `g` is registered on the transition.
- `LOCK` → `IDLE`:
  - Taken on a handshake of port `g` with `req_tlast[g]=1`.
  - At the same time `ptr` ← (`g`+1) mod `NPORTS`.
- Issue path in `LOCK`:
  - `mul_adata`, `mul_bdata`, `mul_tvalid` and `mul_tlast` are combinational pass-throughs of port `g`.
  - `mul_tvalid` is additionally gated by `!tag_full`.
  - `req_tready[g]` = `mul_tready & !tag_full`.
  - All other `req_tready` bits are 0.
- In `IDLE`, `mul_tvalid` and all `req_tready` bits are 0.
- Tag FIFO push: on every `mul_tvalid & mul_tready`, push `g`.
- Tag FIFO fullness:
  - `tag_full` is derived from the registered count.
  - A push is blocked when the FIFO is full, even if a pop happens in the same cycle.
- Return path, when the tag FIFO is non-empty with head `h`:
  - `out_tvalid[h]` = `mul_out_tvalid`; all other `out_tvalid` bits are 0.
  - `mul_out_tready` = `out_tready[h]`.
  - `out_pdata` = `mul_pdata`; `out_tlast` = `mul_out_tlast`.
  - On `mul_out_tvalid & out_tready[h]`, pop the FIFO.
- Return path, when the tag FIFO is empty:
  - `mul_out_tready` = 1, so any product is drained and dropped.
  - All `out_tvalid` bits are 0.
  - A product arriving (`mul_out_tvalid=1`) sets `tag_err`.
- Issue and return paths are independent. Simultaneous push and pop leaves the count unchanged.
- Packets are never interleaved. A requester that deasserts `tvalid` mid-packet keeps the grant.

## Timing
- Reset values:
  - State `IDLE`, `ptr`=0, tag FIFO empty, `tag_err`=0.
  - All `req_tready`=0, `mul_tvalid`=0, `out_tvalid`=0, `busy`=0.
- Assertion of `reset` mid-operation:
  - Flushes the tag FIFO and releases the grant immediately.
  - Products still in flight afterwards are dropped and flag `tag_err`.
  - The multiplier is reset from the same signal.
- Arbitration cost: one bubble cycle per packet. The grant is registered in the cycle after `req_tvalid` is seen in `IDLE`; the first beat can issue in the following cycle.
- Throughput within a packet: one beat per cycle while `mul_tready=1` and the tag FIFO is not full.
- Added latency from `mul_*` to `out_*`: 0 cycles (combinational routing).
- Back-to-back packets on the same port: that port is re-granted only if no other port is valid.

## Test plan
- **Single port:** port 0 sends a 4-beat packet with a=(1,0), b=(3,4) → four products (3,4) with `out_tvalid`=4'b0001, `out_tlast` on beat 4, and `busy` low afterwards.
- **Round-robin fairness:** all 4 ports hold 2-beat packets → grant order 0,1,2,3,0; exactly 1 idle cycle between packets.
- **Backpressure:** `out_tready[2]`=0 while port 2's products return → `mul_out_tready`=0; the tag FIFO fills to 8; `req_tready[2]` drops; no beat is lost after release.
- **Wrap-around:** `ptr`=3 with ports 1 and 3 valid → port 3 is granted first, then port 1.
- **Spurious product:** `mul_out_tvalid` pulses with the FIFO empty → product dropped, `tag_err`=1 and it stays set until reset.
- **Reset mid-packet:** `reset` asserted after beat 2 of 5 → outputs return to reset values in the same cycle; after release, a new packet from port 1 completes correctly.
